// File: rtl/uart_rx.sv
// Purpose : UART 8N1 receiver, LSB first, 16x oversampling with divider cdr.
// Latency : rdata/rxne update 9.5 bit periods + 3 clk after the start edge at the pin.
// Backpres: none; a byte landing on an unread rxne overwrites it and sets rxerr.
//
// Ports: clk/rst (async active-high); en receiver enable; cdr tick divider
// (tick period = cdr+1 clk); sin async serial input; rdr_read / err_clr
// single-cycle clear pulses; rdata last byte; rxne data valid; rxerr sticky
// framing/overrun; busy frame in progress.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 voting at ticks 7/8/9.
module uart_rx #(
    parameter int OVS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] cdr,
    input  logic       sin,
    input  logic       rdr_read,
    input  logic       err_clr,
    output logic [7:0] rdata,
    output logic       rxne,
    output logic       rxerr,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [3:0] LAST = 4'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DEC_START = 4'd9;
`else
    localparam logic [3:0] DEC_START = 4'd8;
`endif

    state_t     state, state_n;
    logic       sin_m, sin_s, sin_q;
    logic [7:0] tcnt;
    logic [3:0] scnt;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic       fall, tick, bit_val;
    logic [3:0] dec_pt;
    logic       dec;
    logic       realign, samp_bit, done_ok, done_bad;

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_m <= 1'b1;
            sin_s <= 1'b1;
            sin_q <= 1'b1;
        end else begin
            sin_m <= sin;
            sin_s <= sin_m;
            sin_q <= sin_s;
        end
    end

    assign fall = sin_q & ~sin_s;
    assign tick = (state != IDLE) && (tcnt == cdr);
    assign busy = (state != IDLE);

    // START decides mid start bit; after realignment every later decision
    // lands on sample-counter value LAST, i.e. the same phase of each bit.
    assign dec_pt = (state == START) ? DEC_START : LAST;
    assign dec    = tick && (scnt == dec_pt);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maj_s <= 2'b11;
        end else if (tick) begin
            if (scnt == 4'(dec_pt - 4'd2)) maj_s[0] <= sin_s;
            if (scnt == 4'(dec_pt - 4'd1)) maj_s[1] <= sin_s;
        end
    end
    assign bit_val = (maj_s[0] & maj_s[1]) | (maj_s[0] & sin_s) | (maj_s[1] & sin_s);
`else
    assign bit_val = sin_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        realign  = 1'b0;
        samp_bit = 1'b0;
        done_ok  = 1'b0;
        done_bad = 1'b0;
        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (fall) state_n = START;
                START: if (dec) begin
                    if (!bit_val) begin
                        state_n = DATA;
                        realign = 1'b1;
                    end else begin
                        state_n = IDLE;   // start-bit glitch, no flags
                    end
                end
                DATA: if (dec) begin
                    samp_bit = 1'b1;
                    if (bitcnt == 3'd7) state_n = STOP;
                end
                STOP: if (dec) begin
                    state_n  = IDLE;
                    done_ok  = bit_val;
                    done_bad = ~bit_val;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Counters are held at zero while idle or disabled, so the start edge
    // always begins a frame from a clean count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt   <= 8'd0;
            scnt   <= 4'd0;
            bitcnt <= 3'd0;
            shreg  <= 8'd0;
        end else if (!en || state == IDLE) begin
            tcnt   <= 8'd0;
            scnt   <= 4'd0;
            bitcnt <= 3'd0;
        end else begin
            tcnt <= tick ? 8'd0 : tcnt + 8'd1;
            if (tick) scnt <= realign ? 4'd0 : scnt + 4'd1;
            if (samp_bit) begin
                shreg[bitcnt] <= bit_val;
                bitcnt        <= bitcnt + 3'd1;
            end
        end
    end

    // Set beats clear for both flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'h00;
            rxne  <= 1'b0;
            rxerr <= 1'b0;
        end else begin
            if (done_ok) begin
                rdata <= shreg;
                rxne  <= 1'b1;
            end else if (rdr_read) begin
                rxne  <= 1'b0;
            end
            if (done_bad || (done_ok && rxne && !rdr_read)) rxerr <= 1'b1;
            else if (err_clr)                               rxerr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] cdr;
    logic       sin;
    logic       rdr_read;
    logic       err_clr;
    logic [7:0] rdata;
    logic       rxne;
    logic       rxerr;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    uart_rx dut (
        .clk(clk), .rst(rst), .en(en), .cdr(cdr), .sin(sin),
        .rdr_read(rdr_read), .err_clr(err_clr),
        .rdata(rdata), .rxne(rxne), .rxerr(rxerr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; bit period follows the current cdr. gl = clk index
    // forced low for one clk, rd = clk index carrying an rdr_read pulse.
    task automatic send_frame(input logic [7:0] d, input logic stopv,
                              input int gl, input int rd);
        int bp = 16 * (int'(cdr) + 1);
        logic [9:0] frame;
        frame = {stopv, d, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 sin = 1'b1;
        end
        for (int c = 0; c < 10 * bp; c++) begin
            @(posedge clk); #1;
            sin      = (c == gl) ? 1'b0 : frame[c / bp];
            rdr_read = (c == rd);
        end
        @(posedge clk); #1 rdr_read = 1'b0;
    endtask

    // Bounded wait for the receiver to go idle, then compare against the
    // oldest expected byte.
    task automatic check_frame(input string tag);
        logic [7:0] ex;
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_rdata"}, rdata, ex);
    endtask

    task automatic pulse_rd();
        @(posedge clk); #1 rdr_read = 1'b1;
        @(posedge clk); #1 rdr_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_ec();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic bad;
        logic seen;
        rst = 1'b1; en = 1'b0; cdr = 8'd0; sin = 1'b1;
        rdr_read = 1'b0; err_clr = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rxne", rxne, 0);
        chk("rst_rxerr", rxerr, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0; en = 1'b1;

        // Idle line for 1000 clk
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            bad |= (rdata !== 8'h00) | (rxne !== 1'b0) | (rxerr !== 1'b0) | (busy !== 1'b0);
        end
        chk("idle_quiet", bad, 0);

        // Basic receive at 16 clk/bit
        cdr = 8'd0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1);
        check_frame("basic");
        chk("basic_rxne", rxne, 1);
        chk("basic_rxerr", rxerr, 0);
        pulse_rd();
        chk("basic_rd_clr", rxne, 0);

        // Framing error, line then held low
        cdr = 8'd3;
        send_frame(8'h3C, 1'b0, -1, -1);
        @(negedge clk);
        chk("fe_rxerr", rxerr, 1);
        chk("fe_rxne", rxne, 0);
        chk("fe_rdata", rdata, 8'hA5);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            seen |= busy;
        end
        chk("fe_no_retrigger", seen, 0);
        pulse_ec();
        chk("fe_err_clr", rxerr, 0);
        @(posedge clk); #1 sin = 1'b1;

        // Overrun
        cdr = 8'd0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1);
        check_frame("ovr1");
        chk("ovr1_rxerr", rxerr, 0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, -1, -1);
        check_frame("ovr2");
        chk("ovr2_rxne", rxne, 1);
        chk("ovr2_rxerr", rxerr, 1);
        pulse_ec();
        chk("ovr_err_clr", rxerr, 0);
        chk("ovr_rxne_kept", rxne, 1);

        // Read coincident with completion: stop decision lands at clk 155
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, -1, 155 + MAJ);
        check_frame("simul");
        chk("simul_rxne", rxne, 1);
        chk("simul_rxerr", rxerr, 0);
        pulse_rd();
        chk("simul_rd_clr", rxne, 0);

        // 4-clk start glitch
        seen = 1'b0;
        for (int i = 0; i < 44; i++) begin
            @(posedge clk); #1 sin = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            seen |= busy;
        end
        chk("glitch_seen_busy", seen, 1);
        chk("glitch_idle", busy, 0);
        chk("glitch_rxne", rxne, 0);
        chk("glitch_rxerr", rxerr, 0);
        chk("glitch_rdata", rdata, 8'h33);

        // Disable mid-byte
        cdr = 8'd1;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk); #1 sin = (i < 32) ? 1'b0 : ((i < 64) ? 1'b0 : 1'b1);
        end
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_rxne", rxne, 0);
        @(posedge clk); #1 sin = 1'b1;
        repeat (20) @(posedge clk);
        #1 en = 1'b1;
        repeat (20) @(posedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1, -1);
        check_frame("after_abort");
        chk("after_abort_rxne", rxne, 1);
        chk("after_abort_rxerr", rxerr, 0);
        pulse_rd();

        // One-clk glitch in the middle of data bit 3's sample window
        cdr = 8'd0;
        exp_q.push_back((MAJ != 0) ? 8'hFF : 8'hF7);
        send_frame(8'hFF, 1'b1, 73, -1);
        check_frame("maj_glitch");
        chk("maj_rxerr", rxerr, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
